// File: rtl/lsu_tracker_if.sv
// Bundle of the lsu_tracker scheduler, memory and scoreboard signals.
// master = tracker side, slave = scheduler/memory/scoreboard side.
interface lsu_tracker_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  issue_valid;
   logic                  issue_ready;
   logic [1:0]            issue_warp;
   logic [3:0]            issue_mask;
   logic                  issue_we;
   logic [DATA_WIDTH-1:0] issue_addr;
   logic [DATA_WIDTH-1:0] issue_data;

   logic                  mem_req_valid;
   logic                  mem_req_ready;
   logic [DATA_WIDTH-1:0] mem_req_addr;
   logic [DATA_WIDTH-1:0] mem_req_data;
   logic                  mem_req_we;
   logic                  mem_resp_valid;
   logic [DATA_WIDTH-1:0] mem_resp_data;

   logic                  done_bit;
   logic [1:0]            warp_num_clear;
   logic [3:0]            threads_mask_clear;
   logic                  wb_valid;
   logic [DATA_WIDTH-1:0] wb_data;
   logic                  err;

   modport master (
      input  issue_valid, issue_warp, issue_mask, issue_we, issue_addr, issue_data,
      output issue_ready,
      output mem_req_valid, mem_req_addr, mem_req_data, mem_req_we,
      input  mem_req_ready, mem_resp_valid, mem_resp_data,
      output done_bit, warp_num_clear, threads_mask_clear, wb_valid, wb_data, err
   );

   modport slave (
      output issue_valid, issue_warp, issue_mask, issue_we, issue_addr, issue_data,
      input  issue_ready,
      input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_we,
      output mem_req_ready, mem_resp_valid, mem_resp_data,
      input  done_bit, warp_num_clear, threads_mask_clear, wb_valid, wb_data, err
   );
endinterface

// File: rtl/lsu_tracker.sv
// In-order load/store tracker: FIFO of issued memory ops, request channel, in-order completion.
// Optional watchdog error enabled by defining LSU_TRACKER_TIMEOUT_EN.
module lsu_tracker #(
   parameter int DATA_WIDTH     = 16,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic           clk,
   input logic           reset,
   lsu_tracker_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef struct packed {
      logic [1:0]            warp;
      logic [3:0]            mask;
      logic                  we;
      logic [DATA_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("lsu_tracker: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
   end

   entry_t        entries [DEPTH];
   logic [PW-1:0] tail;
   logic [PW-1:0] send;
   logic [PW-1:0] head;
   logic [PW-1:0] occupancy;
   logic          issue_fire;
   logic          req_fire;
   logic          outstanding;
   logic          pop;

   // Space is judged from registered pointers, so a pop frees a slot only from the next cycle.
   assign occupancy       = tail - head;
   assign bus.issue_ready = occupancy < PW'(DEPTH);
   assign issue_fire      = bus.issue_valid && bus.issue_ready;

   assign bus.mem_req_valid = send != tail;
   assign bus.mem_req_addr  = entries[send[AW-1:0]].addr;
   assign bus.mem_req_data  = entries[send[AW-1:0]].data;
   assign bus.mem_req_we    = entries[send[AW-1:0]].we;
   assign req_fire          = bus.mem_req_valid && bus.mem_req_ready;

   assign outstanding = send != head;
   assign pop         = bus.mem_resp_valid && outstanding;

   // NOTE: the entry storage has no reset; pointers alone define which entries are live,
   // which keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (issue_fire) begin
         entries[tail[AW-1:0]] <= '{warp: bus.issue_warp, mask: bus.issue_mask,
                                    we: bus.issue_we, addr: bus.issue_addr,
                                    data: bus.issue_data};
      end
   end

   // NOTE: non-blocking assignments so every pointer samples the pre-edge state of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         tail <= '0;
         send <= '0;
         head <= '0;
      end else begin
         if (issue_fire) tail <= tail + PW'(1);
         if (req_fire)   send <= send + PW'(1);
         if (pop)        head <= head + PW'(1);
      end
   end

   // Completion strobe; clear/writeback fields hold their last value between pops.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.done_bit           <= 1'b0;
         bus.wb_valid           <= 1'b0;
         bus.warp_num_clear     <= '0;
         bus.threads_mask_clear <= '0;
         bus.wb_data            <= '0;
      end else begin
         bus.done_bit <= pop;
         bus.wb_valid <= pop && !entries[head[AW-1:0]].we;
         if (pop) begin
            bus.warp_num_clear     <= entries[head[AW-1:0]].warp;
            bus.threads_mask_clear <= entries[head[AW-1:0]].mask;
         end
         if (pop && !entries[head[AW-1:0]].we) bus.wb_data <= bus.mem_resp_data;
      end
   end

`ifdef LSU_TRACKER_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [WW-1:0] wd_count;
   logic          err_q;

   // err rises on the edge where the count reaches TIMEOUT_CYCLES; the count then saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         wd_count <= '0;
         err_q    <= 1'b0;
      end else begin
         if (pop || !outstanding) begin
            wd_count <= '0;
         end else if (wd_count != WW'(TIMEOUT_CYCLES)) begin
            wd_count <= wd_count + WW'(1);
            if (wd_count == WW'(TIMEOUT_CYCLES - 1)) err_q <= 1'b1;
         end
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_lsu_tracker.sv
// Directed self-checking bench for lsu_tracker; watchdog cases run when LSU_TRACKER_TIMEOUT_EN is defined.
module tb_lsu_tracker;
   localparam int DW = 16;
`ifdef LSU_TRACKER_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 64;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   lsu_tracker_if #(.DATA_WIDTH(DW)) bus ();

   lsu_tracker #(
      .DATA_WIDTH    (DW),
      .DEPTH         (4),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle 1 ns past it, so checks and drives avoid the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_issue(input logic v, input logic [1:0] w, input logic [3:0] m,
                              input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
      bus.issue_valid = v;
      bus.issue_warp  = w;
      bus.issue_mask  = m;
      bus.issue_we    = we;
      bus.issue_addr  = a;
      bus.issue_data  = d;
   endtask

   task automatic drive_resp(input logic v, input logic [DW-1:0] d);
      bus.mem_resp_valid = v;
      bus.mem_resp_data  = d;
   endtask

   task automatic check_done(input string tag, input logic d, input logic [1:0] w,
                             input logic [3:0] m, input logic wv, input logic [DW-1:0] wd);
      check({tag, ".done"}, bus.done_bit, d);
      check({tag, ".warp"}, bus.warp_num_clear, w);
      check({tag, ".mask"}, bus.threads_mask_clear, m);
      check({tag, ".wb_valid"}, bus.wb_valid, wv);
      check({tag, ".wb_data"}, bus.wb_data, wd);
   endtask

   task automatic check_idle(input string tag);
      check_done(tag, 1'b0, 2'd0, 4'h0, 1'b0, '0);
      check({tag, ".issue_ready"}, bus.issue_ready, 1'b1);
      check({tag, ".req_valid"}, bus.mem_req_valid, 1'b0);
      check({tag, ".err"}, bus.err, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      drive_issue(1'b0, 2'd0, 4'h0, 1'b0, '0, '0);
      drive_resp(1'b0, '0);
      bus.mem_req_ready = 1'b0;
      step();
      step();
      check_idle("reset");
      reset = 1'b0;
      step();
      check_idle("post_reset");

      // Single load, response three cycles after the handshake.
      bus.mem_req_ready = 1'b1;
      drive_issue(1'b1, 2'd2, 4'hF, 1'b0, 16'h0010, 16'h0000);
      step();
      drive_issue(1'b0, 2'd0, 4'h0, 1'b0, '0, '0);
      check("load.req_valid", bus.mem_req_valid, 1'b1);
      check("load.req_addr", bus.mem_req_addr, 16'h0010);
      check("load.req_we", bus.mem_req_we, 1'b0);
      step();
      check("load.req_drained", bus.mem_req_valid, 1'b0);
      step();
      drive_resp(1'b1, 16'hBEEF);
      step();
      drive_resp(1'b0, '0);
      check_done("load.cpl", 1'b1, 2'd2, 4'hF, 1'b1, 16'hBEEF);
      step();
      check_done("load.after", 1'b0, 2'd2, 4'hF, 1'b0, 16'hBEEF);

      // Store: request carries data, completion without writeback.
      drive_issue(1'b1, 2'd1, 4'h3, 1'b1, 16'h0020, 16'h1234);
      step();
      drive_issue(1'b0, 2'd0, 4'h0, 1'b0, '0, '0);
      check("store.req_valid", bus.mem_req_valid, 1'b1);
      check("store.req_we", bus.mem_req_we, 1'b1);
      check("store.req_addr", bus.mem_req_addr, 16'h0020);
      check("store.req_data", bus.mem_req_data, 16'h1234);
      step();
      drive_resp(1'b1, 16'hDEAD);
      step();
      drive_resp(1'b0, '0);
      check_done("store.cpl", 1'b1, 2'd1, 4'h3, 1'b0, 16'hBEEF);

      // Fill with memory stalled, hold a fifth issue, then drain in order.
      bus.mem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_issue(1'b1, 2'(i), 4'(i + 8), 1'b0, 16'(16'h0100 + i), 16'(16'h5000 + i));
         step();
      end
      check("full.issue_ready", bus.issue_ready, 1'b0);
      check("full.req_valid", bus.mem_req_valid, 1'b1);
      drive_issue(1'b1, 2'd2, 4'h1, 1'b1, 16'h01FF, 16'h9999);
      step();
      step();
      check("full.held_ready", bus.issue_ready, 1'b0);
      check("full.addr_stable", bus.mem_req_addr, 16'h0100);
      check("full.data_stable", bus.mem_req_data, 16'h5000);
      drive_issue(1'b0, 2'd0, 4'h0, 1'b0, '0, '0);
      bus.mem_req_ready = 1'b1;
      step();
      check("full.next_addr", bus.mem_req_addr, 16'h0101);
      drive_resp(1'b1, 16'h7000);
      step();
      check_done("full.cpl0", 1'b1, 2'd0, 4'h8, 1'b1, 16'h7000);
      check("full.ready_back", bus.issue_ready, 1'b1);
      for (int i = 1; i < 4; i++) begin
         drive_resp(1'b1, 16'(16'h7000 + i));
         step();
         check_done($sformatf("full.cpl%0d", i), 1'b1, 2'(i), 4'(i + 8), 1'b1,
                    16'(16'h7000 + i));
      end
      drive_resp(1'b0, '0);
      step();
      check("full.drained_req", bus.mem_req_valid, 1'b0);
      check("full.drained_done", bus.done_bit, 1'b0);

      // Ordering: warps 0, 1, 3 complete back-to-back; a stray response is ignored.
      begin
         logic [1:0] warps [3];
         warps[0] = 2'd0;
         warps[1] = 2'd1;
         warps[2] = 2'd3;
         for (int i = 0; i < 3; i++) begin
            drive_issue(1'b1, warps[i], 4'(i + 1), 1'b0, 16'(16'h0200 + i), '0);
            step();
         end
         drive_issue(1'b0, 2'd0, 4'h0, 1'b0, '0, '0);
         step();
         for (int i = 0; i < 3; i++) begin
            drive_resp(1'b1, 16'(16'hA000 + i));
            step();
            check_done($sformatf("order.cpl%0d", i), 1'b1, warps[i], 4'(i + 1), 1'b1,
                       16'(16'hA000 + i));
         end
         drive_resp(1'b1, 16'hFFFF);
         step();
         drive_resp(1'b0, '0);
         check_done("order.stray", 1'b0, 2'd3, 4'h3, 1'b0, 16'hA002);
         step();
         check("order.stray_quiet", bus.done_bit, 1'b0);
      end

      // Reset with two requests outstanding.
      drive_issue(1'b1, 2'd1, 4'h5, 1'b0, 16'h0300, '0);
      step();
      drive_issue(1'b1, 2'd2, 4'h6, 1'b0, 16'h0301, '0);
      step();
      drive_issue(1'b0, 2'd0, 4'h0, 1'b0, '0, '0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle("midrst");
      drive_resp(1'b1, 16'h4444);
      step();
      drive_resp(1'b0, '0);
      check("midrst.resp_ignored", bus.done_bit, 1'b0);
      check("midrst.wb_ignored", bus.wb_valid, 1'b0);

`ifdef LSU_TRACKER_TIMEOUT_EN
      // Watchdog: one request handshaken and never answered.
      drive_issue(1'b1, 2'd0, 4'h1, 1'b0, 16'h0400, '0);
      step();
      drive_issue(1'b0, 2'd0, 4'h0, 1'b0, '0, '0);
      step();
      for (int i = 0; i < 15; i++) step();
      check("wd.before", bus.err, 1'b0);
      step();
      check("wd.fire", bus.err, 1'b1);
      for (int i = 0; i < 5; i++) step();
      check("wd.sticky", bus.err, 1'b1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("wd.reset", bus.err, 1'b0);

      // Response at cycle 10 keeps the watchdog quiet.
      drive_issue(1'b1, 2'd0, 4'h1, 1'b0, 16'h0400, '0);
      step();
      drive_issue(1'b0, 2'd0, 4'h0, 1'b0, '0, '0);
      step();
      for (int i = 0; i < 9; i++) step();
      drive_resp(1'b1, 16'h0001);
      step();
      drive_resp(1'b0, '0);
      check("wd.resp_done", bus.done_bit, 1'b1);
      for (int i = 0; i < 30; i++) step();
      check("wd.quiet", bus.err, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
